// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner and sequencer for a shared 1-bit-per-cycle multiply/divide datapath.
// Raises a pipeline stall while a MULT/DIV is in flight so the issuer waits in EX for its result.
module hilo_muldiv_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              op_valid,
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              stallreq_for_muldiv,
    output logic              busy,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     opnd;
    logic                  is_div;
    logic                  res_neg;
    logic                  rem_neg;

    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;

    // Only an exact one-hot opcode is honoured; flush blocks acceptance outright.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        if (op_valid && !flush) begin
            case (op)
                6'b100000: op_mult  = 1'b1;
                6'b010000: op_multu = 1'b1;
                6'b001000: op_div   = 1'b1;
                6'b000100: op_divu  = 1'b1;
                6'b000010: op_mthi  = 1'b1;
                6'b000001: op_mtlo  = 1'b1;
                default: ;
            endcase
        end
    end

    logic signed_op, a_neg, b_neg;
    logic [DATA_W-1:0] mag_a, mag_b;

    assign signed_op = op_mult | op_div;
    assign a_neg     = signed_op & src_a[DATA_W-1];
    assign b_neg     = signed_op & src_b[DATA_W-1];
    assign mag_a     = a_neg ? -src_a : src_a;
    assign mag_b     = b_neg ? -src_b : src_b;

    // Multiply: multiplier sits in acc low half and shifts out as partial sums shift in.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; a negative trial difference restores.
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;
    assign rem_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_diff = rem_sh - {1'b0, opnd};
    assign div_next = div_diff[DATA_W]
                    ? {rem_sh[DATA_W-1:0],   acc[DATA_W-2:0], 1'b0}
                    : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    assign prod_fix = res_neg ? -acc : acc;
    assign quo_fix  = res_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix  = rem_neg ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments only; datapath regs reset too for a clean start.
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (op_mthi) begin
                        hi_o <= src_a;
                    end else if (op_mtlo) begin
                        lo_o <= src_a;
                    end else if (op_mult || op_multu) begin
                        acc     <= {{DATA_W{1'b0}}, mag_b};
                        opnd    <= mag_a;
                        is_div  <= 1'b0;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= 1'b0;
                        state   <= S_MUL;
                    end else if ((op_div || op_divu) && src_b == '0) begin
                        hi_o  <= src_a;
                        lo_o  <= '1;
                        state <= S_DONE;
                    end else if (op_div || op_divu) begin
                        acc     <= {{DATA_W{1'b0}}, mag_a};
                        opnd    <= mag_b;
                        is_div  <= 1'b1;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        state   <= S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= (state == S_MUL) ? mul_next : div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi_o <= rem_fix;
                            lo_o <= quo_fix;
                        end else begin
                            hi_o <= prod_fix[2*DATA_W-1:DATA_W];
                            lo_o <= prod_fix[DATA_W-1:0];
                        end
                        state <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign stallreq_for_muldiv = (state == S_IDLE)
                               ? (op_mult | op_multu | op_div | op_divu)
                               : (state == S_MUL || state == S_DIV || state == S_FIX);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl: latency, arithmetic corners, flush and reset.
module tb_hilo_muldiv_ctrl;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        op_valid;
    logic [5:0]  op;
    logic [31:0] src_a, src_b;
    logic        stallreq_for_muldiv, busy;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    int n;

    hilo_muldiv_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .flush               (flush),
        .op_valid            (op_valid),
        .op                  (op),
        .src_a               (src_a),
        .src_b               (src_b),
        .stallreq_for_muldiv (stallreq_for_muldiv),
        .busy                (busy),
        .hi_o                (hi_o),
        .lo_o                (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op and count stall cycles until DONE; leaves op_valid asserted.
    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int stalls);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        stalls   = 0;
        #1;
        while (stallreq_for_muldiv && stalls < 100) begin
            stalls++;
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
        #12;
        check("rst_hi", 64'(hi_o), 64'h0);
        check("rst_lo", 64'(lo_o), 64'h0);
        check("rst_stall", 64'(stallreq_for_muldiv), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        @(negedge clk); resetn = 1'b1;
        tick();

        // MULT -3 * 5
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, n);
        check("mult_stalls", 64'(n), 64'd34);
        op_valid = 1'b0;
        check("mult_done_busy", 64'(busy), 64'h1);
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFF1);
        tick();
        check("mult_after_busy", 64'(busy), 64'h0);

        // DIVU 100 / 7
        run_op(OP_DIVU, 32'd100, 32'd7, n);
        op_valid = 1'b0;
        check("divu_stalls", 64'(n), 64'd34);
        check("divu_lo", 64'(lo_o), 64'h0000_000E);
        check("divu_hi", 64'(hi_o), 64'h0000_0002);
        tick();

        // DIV -7 / 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        op_valid = 1'b0;
        check("div_neg_lo", 64'(lo_o), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi_o), 64'hFFFF_FFFF);
        tick();

        // DIV by zero: single stall cycle, DONE, then IDLE
        run_op(OP_DIV, 32'h1234_5678, 32'd0, n);
        op_valid = 1'b0;
        check("div0_stalls", 64'(n), 64'd1);
        check("div0_hi", 64'(hi_o), 64'h1234_5678);
        check("div0_lo", 64'(lo_o), 64'hFFFF_FFFF);
        check("div0_done_busy", 64'(busy), 64'h1);
        tick();
        check("div0_idle_busy", 64'(busy), 64'h0);

        // Signed corner cases
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, n);
        op_valid = 1'b0;
        check("mult_min_hi", 64'(hi_o), 64'h4000_0000);
        check("mult_min_lo", 64'(lo_o), 64'h0);
        tick();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        op_valid = 1'b0;
        check("div_wrap_lo", 64'(lo_o), 64'h8000_0000);
        check("div_wrap_hi", 64'(hi_o), 64'h0);
        tick();

        // MTHI then MTLO on consecutive cycles
        op_valid = 1'b1; op = OP_MTHI; src_a = 32'h1234; #1;
        check("mthi_stall", 64'(stallreq_for_muldiv), 64'h0);
        tick();
        check("mthi_hi", 64'(hi_o), 64'h1234);
        op = OP_MTLO; src_a = 32'hABCD; #1;
        check("mtlo_stall", 64'(stallreq_for_muldiv), 64'h0);
        tick();
        op_valid = 1'b0;
        check("mtlo_lo", 64'(lo_o), 64'hABCD);
        check("mt_hi_kept", 64'(hi_o), 64'h1234);
        check("mt_busy", 64'(busy), 64'h0);

        // MULTU max*max with op_valid held through DONE, then MTLO 7
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("multu_stalls", 64'(n), 64'd34);
        check("multu_hi", 64'(hi_o), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo_o), 64'h1);
        tick();
        check("multu_no_restart", 64'(busy), 64'h0);
        op = OP_MTLO; src_a = 32'd7; #1;
        check("mtlo7_stall", 64'(stallreq_for_muldiv), 64'h0);
        tick();
        op_valid = 1'b0;
        check("mtlo7_lo", 64'(lo_o), 64'h7);
        check("mtlo7_busy", 64'(busy), 64'h0);

        // flush in IDLE suppresses an MTHI write
        op_valid = 1'b1; op = OP_MTHI; src_a = 32'h5555; flush = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        check("flush_idle_hi", 64'(hi_o), 64'hFFFF_FFFE);

        // DIV flushed at iteration 10
        op_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        tick();
        repeat (10) tick();
        check("flush_pre_stall", 64'(stallreq_for_muldiv), 64'h1);
        flush = 1'b1; op_valid = 1'b0;
        tick();
        flush = 1'b0; #1;
        check("flush_stall", 64'(stallreq_for_muldiv), 64'h0);
        check("flush_busy", 64'(busy), 64'h0);
        repeat (40) tick();
        check("flush_hi", 64'(hi_o), 64'hFFFF_FFFE);
        check("flush_lo", 64'(lo_o), 64'h7);

        // Asynchronous reset mid-MULT
        op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
        tick();
        repeat (5) tick();
        check("prerst_busy", 64'(busy), 64'h1);
        #2 resetn = 1'b0; op_valid = 1'b0;
        #1;
        check("arst_hi", 64'(hi_o), 64'h0);
        check("arst_lo", 64'(lo_o), 64'h0);
        check("arst_stall", 64'(stallreq_for_muldiv), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        @(negedge clk); resetn = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
